pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding unit and generates every pipeline-register write-enable, bubble and flush. It covers:
- load-use hazards that forwarding cannot resolve;
- taken-branch and jump redirects;
- freezes while a variable-latency data memory is busy, with a timeout watchdog.

It also keeps saturating per-cause stall statistics.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-zero constant,
// NOP encoding, and the register-dependency helper used by hazard detection.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // True when a consumer really reads src and src is a live (non-$0) destination.
  function automatic logic reads_reg(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch/jump
// redirects, data-memory freezes with a timeout watchdog, and stall statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsStore,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rw,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  input  logic             Clear_Stats,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             MEM_WB_Bubble,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  hz_state_t      state, state_next;
  logic [WCW-1:0] wait_cnt, wait_cnt_next;
  logic           freeze, load_use, load_stall, redirect;

  // Store data from a load is forwarded at MEM, so a store's Rt never stalls.
  assign load_use = EX_MemRead &&
                    (reads_reg(ID_UsesRs, ID_Rs, EX_Rw) ||
                     reads_reg(ID_UsesRt && !ID_IsStore, ID_Rt, EX_Rw));
  assign freeze     = (MEM_Req && !MEM_Ready) || (state == TIMEOUT);
  assign load_stall = !freeze && !EX_BranchTaken && load_use;
  assign redirect   = !freeze && (EX_BranchTaken || (ID_Jump && !load_use));
  assign MemTimeout = (state == TIMEOUT);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    MEM_WB_Bubble = 1'b0;

    case (state)
      RUN: begin
        if (MEM_Req && !MEM_Ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WCW'(1);
        end
      end
      MEM_WAIT: begin
        // Ready completes the access; Req dropping without Ready is a protocol slip.
        if (MEM_Ready || !MEM_Req) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
          if (wait_cnt_next == WCW'(WAIT_LIMIT)) state_next = TIMEOUT;
        end
      end
      TIMEOUT: state_next = TIMEOUT;
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase

    if (!Reset_L) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (freeze) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // Index 0: load-use stalls, 1: redirect flushes, 2: frozen cycles.
  logic [2:0]       stat_inc;
  logic [CNT_W-1:0] stat_cnt [3];

  assign stat_inc = {freeze, redirect, load_stall};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk  (CLK),
      .rst_n(Reset_L),
      .inc  (stat_inc[gi]),
      .clr  (Clear_Stats),
      .count(stat_cnt[gi])
    );
  end

  assign LoadStallCnt = stat_cnt[0];
  assign FlushCnt     = stat_cnt[1];
  assign MemWaitCnt   = stat_cnt[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int LIMIT = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          CLK, Reset_L;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rw;
  logic          ID_UsesRs, ID_UsesRt, ID_IsStore, ID_Jump;
  logic          EX_MemRead, EX_BranchTaken, MEM_Req, MEM_Ready, Clear_Stats;
  logic          PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic          IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, MemTimeout;
  logic [CW-1:0] LoadStallCnt, FlushCnt, MemWaitCnt;
  logic [6:0]    dut_ctl;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsStore(ID_IsStore), .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead),
    .EX_Rw(EX_Rw), .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req),
    .MEM_Ready(MEM_Ready), .Clear_Stats(Clear_Stats),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .MEM_WB_Bubble(MEM_WB_Bubble),
    .MemTimeout(MemTimeout), .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt),
    .MemWaitCnt(MemWaitCnt)
  );

  assign dut_ctl = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                    IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rs, rt, rw;
    logic       urs, urt, st, jmp, mr, br, req, rdy, clr;
    logic [6:0] want;  // {pc, if_id, id_ex, ex_mem, flush, id_ex_bubble, mem_wb_bubble}
    string      name;
  } vec_t;

  int npass = 0;
  int ntotal = 0;

  // Reference model: consecutive frozen cycles, sticky timeout, plain integer counters.
  int waits, lcnt, fcnt, wcnt;
  bit tmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    ntotal++;
    if (act === want) npass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, want);
  endtask

  function automatic vec_t mkv(input int rs, input int rt, input int urs, input int urt,
                               input int st, input int jmp, input int mr, input int rw,
                               input int br, input int req, input int rdy,
                               input logic [6:0] want, input string name);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rw = 5'(rw);
    v.urs = 1'(urs); v.urt = 1'(urt); v.st = 1'(st); v.jmp = 1'(jmp);
    v.mr = 1'(mr); v.br = 1'(br); v.req = 1'(req); v.rdy = 1'(rdy);
    v.clr = 1'b0; v.want = want; v.name = name;
    return v;
  endfunction

  function automatic bit ref_lu();
    return EX_MemRead && (EX_Rw != 0) &&
           ((ID_UsesRs && ID_Rs == EX_Rw) || (ID_UsesRt && ID_Rt == EX_Rw && !ID_IsStore));
  endfunction

  function automatic bit ref_frz();
    return tmo || (MEM_Req && !MEM_Ready);
  endfunction

  function automatic logic [6:0] ref_ctl();
    if (!Reset_L)       return 7'b0000111;
    if (ref_frz())      return 7'b0000001;
    if (EX_BranchTaken) return 7'b1111110;
    if (ref_lu())       return 7'b0011010;
    if (ID_Jump)        return 7'b1111100;
    return 7'b1111000;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic model_clock();
    bit frz = ref_frz();
    bit lu  = ref_lu();
    if (Clear_Stats) begin
      lcnt = 0; fcnt = 0; wcnt = 0;
    end else begin
      lcnt = sat(lcnt + int'(!frz && !EX_BranchTaken && lu));
      fcnt = sat(fcnt + int'(!frz && (EX_BranchTaken || (ID_Jump && !lu))));
      wcnt = sat(wcnt + int'(frz));
    end
    if (!tmo) begin
      if (frz) begin
        waits++;
        if (waits >= LIMIT) tmo = 1'b1;
      end else begin
        waits = 0;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; EX_Rw = v.rw;
    ID_UsesRs = v.urs; ID_UsesRt = v.urt; ID_IsStore = v.st; ID_Jump = v.jmp;
    EX_MemRead = v.mr; EX_BranchTaken = v.br; MEM_Req = v.req; MEM_Ready = v.rdy;
    Clear_Stats = v.clr;
  endtask

  task automatic step(input vec_t v, input bit use_want);
    @(negedge CLK);
    apply(v);
    #1;
    chk({"ctl_model ", v.name}, 32'(dut_ctl), 32'(ref_ctl()));
    if (use_want) chk({"ctl_table ", v.name}, 32'(dut_ctl), 32'(v.want));
    chk("MemTimeout", 32'(MemTimeout), 32'(tmo));
    chk("LoadStallCnt", 32'(LoadStallCnt), 32'(lcnt));
    chk("FlushCnt", 32'(FlushCnt), 32'(fcnt));
    chk("MemWaitCnt", 32'(MemWaitCnt), 32'(wcnt));
    @(posedge CLK);
    model_clock();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ctl"}, 32'(dut_ctl), 32'(7'b0000111));
    chk({tag, " MemTimeout"}, 32'(MemTimeout), 32'd0);
    chk({tag, " LoadStallCnt"}, 32'(LoadStallCnt), 32'd0);
    chk({tag, " FlushCnt"}, 32'(FlushCnt), 32'd0);
    chk({tag, " MemWaitCnt"}, 32'(MemWaitCnt), 32'd0);
  endtask

  // Asynchronous reset pulse away from clock edges, with noisy inputs during reset.
  task automatic do_reset(input string tag);
    vec_t v;
    @(negedge CLK);
    #2;
    Reset_L = 1'b0;
    v = mkv($urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 0, 1, 1,
            $urandom_range(0, 31), 1, 1, 0, 7'd0, "noise");
    apply(v);
    #1;
    check_reset_state({tag, " async"});
    @(posedge CLK);
    #2;
    check_reset_state({tag, " held"});
    waits = 0; tmo = 1'b0; lcnt = 0; fcnt = 0; wcnt = 0;
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, "idle"));
    @(negedge CLK);
    Reset_L = 1'b1;
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    Reset_L = 1'b0;
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0, "idle"));
    waits = 0; tmo = 1'b0; lcnt = 0; fcnt = 0; wcnt = 0;
    #1;
    check_reset_state("por");
    do_reset("reset");

    //                rs rt urs urt st jmp mr rw br req rdy  want
    vecs[0]  = mkv(5, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 7'b0011010, "lu_rs");
    vecs[1]  = mkv(3, 5, 1, 1, 1, 0, 1, 5, 0, 0, 0, 7'b1111000, "store_no_stall");
    vecs[2]  = mkv(5, 0, 1, 0, 0, 0, 1, 5, 1, 0, 0, 7'b1111110, "branch_over_lu");
    vecs[3]  = mkv(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 7'b1111000, "rw_zero");
    vecs[4]  = mkv(1, 2, 1, 1, 0, 1, 0, 1, 0, 0, 0, 7'b1111100, "jump");
    vecs[5]  = mkv(7, 0, 1, 0, 0, 1, 1, 7, 0, 0, 0, 7'b0011010, "lu_over_jump");
    vecs[6]  = mkv(1, 9, 0, 1, 0, 0, 1, 9, 0, 0, 0, 7'b0011010, "lu_rt");
    vecs[7]  = mkv(1, 9, 1, 0, 0, 0, 1, 9, 0, 0, 0, 7'b1111000, "rt_unused");
    vecs[8]  = mkv(4, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 7'b1111000, "not_load");
    vecs[9]  = mkv(4, 0, 1, 0, 0, 1, 1, 4, 1, 1, 0, 7'b0000001, "freeze");
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111000, "release");
    vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000001, "freeze_branch");
    vecs[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111110, "release_branch");
    for (int i = 0; i < 13; i++) step(vecs[i], 1'b1);

    // Load-use stall lasts one cycle: next cycle the load has left EX.
    do_reset("lu_seq");
    step(vecs[0], 1'b1);
    step(mkv(5, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 7'b1111000, "lu_gone"), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, "idle"), 1'b1);
    chk("lu_seq LoadStallCnt", 32'(LoadStallCnt), 32'd1);

    // Three-cycle memory wait with a branch held; it redirects on release.
    do_reset("wait_seq");
    for (int i = 0; i < 3; i++)
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000001, "wait_frozen"), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1111110, "wait_release"), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, "idle"), 1'b1);
    chk("wait_seq MemWaitCnt", 32'(MemWaitCnt), 32'd3);
    chk("wait_seq FlushCnt", 32'(FlushCnt), 32'd1);

    // Watchdog: after LIMIT wait cycles the freeze is permanent.
    do_reset("tmo_seq");
    for (int i = 0; i < LIMIT; i++)
      step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000001, "tmo_wait"), 1'b1);
    #1;
    chk("tmo_seq MemTimeout", 32'(MemTimeout), 32'd1);
    step(mkv(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 7'b0000001, "tmo_hold"), 1'b1);
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000001, "tmo_hold_rdy"), 1'b1);
    do_reset("tmo_exit");
    step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000, "after_tmo"), 1'b1);

    // Saturation of a counter, then clear beating a same-cycle increment.
    for (int i = 0; i < MAXC + 5; i++)
      step(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1111100, "sat_jump"), 1'b1);
    #1;
    chk("sat FlushCnt", 32'(FlushCnt), 32'(MAXC));
    v = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1111100, "clr_jump");
    v.clr = 1'b1;
    step(v, 1'b1);
    #1;
    chk("clr FlushCnt", 32'(FlushCnt), 32'd0);

    // Randomized traffic against the model, with periodic resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset("rand_reset");
      v = mkv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0), 7'd0, "rand");
      v.clr = ($urandom_range(0, 40) == 0);
      step(v, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
